// File: rtl/mac_accum_if.sv
// Stream bundle for mac_accum: sample input channel and window-result output channel.
// With MAC_ACCUM_PEAK_EN defined the result channel also carries peak_out.
interface mac_accum_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SW = 2 * Width + $clog2(N);

  logic [2*Width-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [SW-1:0]      sum_out;
  logic [2*Width-1:0] avg_out;
  logic               out_valid;
  logic               out_ready;
`ifdef MAC_ACCUM_PEAK_EN
  logic [2*Width-1:0] peak_out;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, sum_out, avg_out, out_valid, peak_out
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, sum_out, avg_out, out_valid, peak_out
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, sum_out, avg_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, sum_out, avg_out, out_valid
  );
`endif
endinterface

// File: rtl/mac_accum.sv
// Windowed accumulator: sums N accepted samples, presents sum and mean, holds until consumed.
// Optional MAC_ACCUM_PEAK_EN adds peak_out, the per-window maximum sample.
module mac_accum #(
  parameter int unsigned Width = 8,
  parameter int unsigned N     = 4
) (
  input logic        clk,
  input logic        reset,
  input logic        clear,
  mac_accum_if.slave bus
);
  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned DW   = 2 * Width;
  localparam int unsigned SW   = DW + CntW;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e          state_q;
  logic [SW-1:0]   acc_q;
  logic [CntW-1:0] cnt_q;
  logic [SW-1:0]   sum_d;
  logic            accept;
  logic            last;

  assign bus.in_ready = (state_q == StAccum);

  always_comb begin
    sum_d  = acc_q + SW'(bus.in_data);
    accept = bus.in_valid && (state_q == StAccum);
    last   = (cnt_q == CntW'(N - 1));
  end

`ifdef MAC_ACCUM_PEAK_EN
  // Running maximum of the current window; published to peak_out when the window closes.
  logic [DW-1:0] peak_q;
  logic [DW-1:0] peak_d;

  always_comb begin
    peak_d = (bus.in_data > peak_q) ? bus.in_data : peak_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q       <= '0;
      bus.peak_out <= '0;
    end else if (state_q == StAccum) begin
      if (clear) begin
        peak_q       <= '0;
        bus.peak_out <= '0;
      end else if (accept) begin
        if (last) begin
          peak_q       <= '0;
          bus.peak_out <= peak_d;
        end else begin
          peak_q <= peak_d;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StAccum;
      acc_q         <= '0;
      cnt_q         <= '0;
      bus.sum_out   <= '0;
      bus.avg_out   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          // clear wins over a sample offered in the same cycle
          if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (accept) begin
            if (last) begin
              bus.sum_out   <= sum_d;
              bus.avg_out   <= sum_d[SW-1:CntW];
              bus.out_valid <= 1'b1;
              acc_q         <= '0;
              cnt_q         <= '0;
              state_q       <= StHold;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          // out_valid is always set here, so out_ready alone completes the handshake
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state_q       <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end
endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter Width, default 8: operand width of the upstream multiply-add stage; input sample width is 2*Width.
REQ-002 SHALL have parameter N, default 4: samples per window; power of two, N >= 2.
REQ-003 SHALL define derived width SW = 2*Width + $clog2(N): sum width (18 at defaults).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous discard of the partial window.
REQ-007 in_data  input  2*Width  unsigned sample, i.e. the registered DATA_OUT of the upstream multiply-add stage.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 sum_out  output  SW  registered window sum.
REQ-011 avg_out  output  2*Width  registered window mean: sum_out >> $clog2(N).
REQ-012 out_valid  output  1  sum_out/avg_out hold a valid result.
REQ-013 out_ready  input  1  downstream consumes the result.

Function
REQ-014 SHALL implement a two-state machine: ACCUM and HOLD.
REQ-015 in_ready SHALL be 1 in ACCUM and 0 in HOLD, combinationally from state only.
REQ-016 Accept SHALL occur when in_valid && in_ready; a sample is consumed exactly once.
REQ-017 In ACCUM, on accept with cnt < N-1: acc <= acc + in_data (zero-extended to SW); cnt <= cnt + 1.
REQ-018 In ACCUM, on accept with cnt == N-1: sum_out <= acc + in_data; avg_out <= (acc + in_data) >> $clog2(N); out_valid <= 1; acc <= 0; cnt <= 0; state -> HOLD.
REQ-019 Latency SHALL be one cycle: sum_out/out_valid are valid on the edge after the Nth accept.
REQ-020 The accumulator SHALL never overflow: SW bits hold N * (2^(2*Width)-1).
REQ-021 In HOLD, on out_valid && out_ready: out_valid <= 0; state -> ACCUM; sum_out/avg_out keep their values.
REQ-022 In HOLD, sum_out, avg_out and out_valid SHALL stay stable while out_ready is 0.
REQ-023 Simultaneous handshake and in_valid in HOLD: the sample is not accepted (in_ready is 0 that cycle); acceptance resumes the next cycle.
REQ-024 Gaps in in_valid SHALL not affect the count; the window closes on the Nth accepted sample only.
REQ-025 clear in ACCUM: acc <= 0; cnt <= 0; any sample presented that cycle is discarded.
REQ-026 clear in HOLD SHALL be ignored.
REQ-027 Peak throughput SHALL be one window per N+1 cycles with out_ready held at 1.

Reset
REQ-028 On reset: state = ACCUM, acc = 0, cnt = 0, sum_out = 0, avg_out = 0, out_valid = 0; reset takes priority over clear and all handshakes.
REQ-029 Reset asserted in HOLD SHALL drop out_valid on the same edge and discard the pending result.

Configuration
REQ-030 Macro MAC_ACCUM_PEAK_EN, when defined, SHALL add output peak_out (2*Width), the unsigned maximum of the window's samples, updated and registered alongside sum_out.
REQ-031 peak_out SHALL reset to 0, restart per window and clear with clear; without the macro the port and its logic SHALL be absent.

Verification (Width=8, N=4)
REQ-032 Assert reset for 2 cycles -> all outputs 0, in_ready=1, out_valid=0.
REQ-033 Samples 10,20,30,40 on consecutive cycles, out_ready=1 -> one cycle after 40: sum_out=100, avg_out=25, out_valid=1 for exactly one cycle.
REQ-034 Four samples of 65025 -> sum_out=260100, avg_out=65025, no wrap.
REQ-035 out_ready=0 after window 1,2,3,4 -> sum_out=10 held, in_ready=0, in_valid samples ignored; raise out_ready -> out_valid falls, next window sums correctly.
REQ-036 Samples 5,7, then clear, then 1,1,1,1 -> sum_out=4; reset during HOLD -> out_valid=0 the next cycle.
REQ-037 With MAC_ACCUM_PEAK_EN: samples 3,200,9,50 -> peak_out=200 and sum_out=262.
